// File: rtl/mem_sort_checker_if.sv
// Data-memory port bundle: word address and write request out,
// registered 1-cycle-latency read data back.
interface mem_sort_checker_if #(
  parameter int ADDR_LEN = 11
);
  logic [ADDR_LEN-1:0] addr;
  logic                wr_req;
  logic [31:0]         wr_data;
  logic [31:0]         rd_data;

  modport master (
    output addr,
    output wr_req,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  addr,
    input  wr_req,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/mem_sort_checker.sv
// Post-sort self-check: streams N words from BASE, checks
// non-decreasing order and the 32-bit sum, reports pass/fail.
module mem_sort_checker #(
  parameter int                  ADDR_LEN = 11,
  parameter int                  N        = 128,
  parameter logic [ADDR_LEN-1:0] BASE     = '0,
  parameter logic [31:0]         EXP_SUM  = 32'h00001FC0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  mem_sort_checker_if.master  mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_LEN:0]   err_count,
  output logic [ADDR_LEN-1:0] first_err_idx,
  output logic [31:0]         sum
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [ADDR_LEN-1:0] LAST = ADDR_LEN'(N - 1);
  localparam logic [ADDR_LEN:0]   EMAX = '1;
  localparam logic [ADDR_LEN-1:0] ONE  = ADDR_LEN'(1);

  logic [1:0]          state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q;
  logic [ADDR_LEN-1:0] cnt_q;
  logic                v0_q, v1_q;
  logic [ADDR_LEN-1:0] idx0_q, idx1_q;
  logic [31:0]         prev_q;
  logic [31:0]         sum_q;
  logic [ADDR_LEN:0]   err_q;
  logic [ADDR_LEN-1:0] fei_q;
  logic                busy_q, done_q, pass_q;

  logic [31:0] word;
  logic        viol;
  logic        last_smp;

  assign word     = mem.rd_data;
  assign viol     = v1_q && (idx1_q != '0)
                    && (word < prev_q);
  assign last_smp = v1_q && (idx1_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start)
          state_d = (N == 1) ? DRAIN : SCAN;
      SCAN:
        if (cnt_q == LAST) state_d = DRAIN;
      DRAIN:
        if (last_smp) state_d = FINISH;
      FINISH:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      cnt_q   <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      idx0_q  <= '0;
      idx1_q  <= '0;
      prev_q  <= '0;
      sum_q   <= '0;
      err_q   <= '0;
      fei_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v0_q    <= 1'b0;
      v1_q    <= v0_q;
      idx1_q  <= idx0_q;

      if (v1_q) begin
        sum_q  <= sum_q + word;
        prev_q <= word;
        if (viol) begin
          if (err_q != EMAX) err_q <= err_q + 1'b1;
          if (err_q == '0) fei_q <= idx1_q;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= BASE;
            cnt_q  <= ONE;
            v0_q   <= 1'b1;
            idx0_q <= '0;
            prev_q <= '0;
            sum_q  <= '0;
            err_q  <= '0;
            fei_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
          end
        end
        SCAN: begin
          addr_q <= BASE + cnt_q;
          v0_q   <= 1'b1;
          idx0_q <= cnt_q;
          cnt_q  <= cnt_q + ONE;
        end
        FINISH: begin
          pass_q <= (err_q == '0) && (sum_q == EXP_SUM);
          done_q <= 1'b1;
          busy_q <= 1'b0;
          addr_q <= BASE;
        end
        default: ;
      endcase
    end
  end

  assign mem.addr      = addr_q;
  assign mem.wr_req    = 1'b0;
  assign mem.wr_data   = '0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = fei_q;
  assign sum           = sum_q;

endmodule
